// File: rtl/niosii_jtag_debug_mem_access_pkg.sv
// Shared types and constants for the JTAG debug memory access engine.
package niosii_jtag_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dbg_state_e;

  localparam int unsigned JDO_W         = 38;
  localparam int unsigned JDO_RD_FLAG   = 35;
  localparam int unsigned JDO_ADDR_LSB  = 2;
  localparam int unsigned JDO_WDATA_LSB = 3;
  localparam int unsigned JDO_WDATA_W   = 32;

  localparam logic [JDO_WDATA_W-1:0] RST_DATA  = '0;
  localparam logic                   RST_READY = 1'b1;
  localparam logic                   RST_ERROR = 1'b0;

  function automatic logic [1:0] strobe_count(input logic a, input logic n, input logic b);
    return {1'b0, a} + {1'b0, n} + {1'b0, b};
  endfunction

endpackage

// File: rtl/niosii_jtag_debug_mem_access_if.sv
// Avalon-MM master bus used by the debug memory access engine.
interface niosii_jtag_debug_mem_access_if
  import niosii_jtag_dbg_pkg::*;
#(
  parameter int unsigned AW = 16
) ();

  logic [AW-1:0]          avm_address;
  logic                   avm_read;
  logic                   avm_write;
  logic [JDO_WDATA_W-1:0] avm_writedata;
  logic [JDO_WDATA_W-1:0] avm_readdata;
  logic                   avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/niosii_jtag_debug_mem_access_timeout.sv
// Saturating stall counter; expire flags the last allowed stalled cycle.
module niosii_jtag_dbg_timeout #(
  parameter int unsigned MAX_COUNT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] LAST = (MAX_COUNT > 0) ? CW'(MAX_COUNT - 1) : '0;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // MAX_COUNT of zero disables the abort entirely.
  assign expire = (MAX_COUNT > 0) && enable && (count_q == LAST);

endmodule

// File: rtl/niosii_jtag_debug_mem_access.sv
// Debug memory access engine: turns ocimem strobes into single Avalon-MM reads/writes.
module niosii_jtag_debug_mem_access
  import niosii_jtag_dbg_pkg::*;
#(
  parameter int unsigned AW             = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [JDO_W-1:0]       jdo,
  input  logic                   take_action_ocimem_a,
  input  logic                   take_no_action_ocimem_a,
  input  logic                   take_action_ocimem_b,
  niosii_jtag_debug_mem_access_if.master avm,
  output logic [JDO_WDATA_W-1:0] MonDReg,
  output logic                   monitor_ready,
  output logic                   monitor_error
);

  dbg_state_e             state_q, state_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [JDO_WDATA_W-1:0] wdata_q, wdata_d;
  logic [JDO_WDATA_W-1:0] mon_q, mon_d;
  logic                   ready_q, ready_d;
  logic                   error_q, error_d;
  logic                   any_strobe, multi_strobe, expire;
  logic                   unused_jdo;

  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_FLAG+1], jdo[JDO_ADDR_LSB-1:0]};

  assign any_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign multi_strobe = strobe_count(take_action_ocimem_a, take_no_action_ocimem_a,
                                     take_action_ocimem_b) > 2'd1;

  niosii_jtag_dbg_timeout #(
    .MAX_COUNT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == IDLE),
    .enable((state_q != IDLE) && avm.avm_waitrequest),
    .expire(expire)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mon_d   = mon_q;
    ready_d = ready_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          addr_d = jdo[JDO_ADDR_LSB +: AW];
          if (jdo[JDO_RD_FLAG]) state_d = RD;
        end else if (take_no_action_ocimem_a) begin
          state_d = RD;
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[JDO_WDATA_LSB +: JDO_WDATA_W];
          state_d = WR;
        end
        if (state_d != IDLE) begin
          error_d = 1'b0;
          ready_d = 1'b0;
        end
        // Dropped losers flag an error after the accept clear.
        if (multi_strobe) error_d = 1'b1;
      end
      RD, WR: begin
        if (any_strobe) error_d = 1'b1;
        if (!avm.avm_waitrequest) begin
          if (state_q == RD) mon_d = avm.avm_readdata;
          addr_d  = addr_q + AW'(1);
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (expire) begin
          error_d = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= RST_DATA;
      mon_q   <= RST_DATA;
      ready_q <= RST_READY;
      error_q <= RST_ERROR;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mon_q   <= mon_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  assign avm.avm_address   = addr_q;
  assign avm.avm_read      = (state_q == RD);
  assign avm.avm_write     = (state_q == WR);
  assign avm.avm_writedata = wdata_q;
  assign MonDReg           = mon_q;
  assign monitor_ready     = ready_q;
  assign monitor_error     = error_q;

endmodule

// File: tb/tb_niosii_jtag_debug_mem_access.sv
// Randomized scoreboard bench for the debug memory access engine with a behavioural slave.
module tb_niosii_jtag_debug_mem_access;

  localparam int unsigned AW = 16;
  localparam int TO = 8;

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [31:0] data;
  } op_t;

  typedef struct {
    logic [31:0] mon;
    bit          err;
    logic [15:0] addr;
    int          reqcyc;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        sa = 1'b0, sn = 1'b0, sb = 1'b0;
  logic [31:0] mon;
  logic        rdy, err;

  int n_checks = 0;
  int n_fail = 0;

  niosii_jtag_debug_mem_access_if #(.AW(AW)) avm ();

  niosii_jtag_debug_mem_access #(
    .AW            (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (sa),
    .take_no_action_ocimem_a(sn),
    .take_action_ocimem_b   (sb),
    .avm                    (avm),
    .MonDReg                (mon),
    .monitor_ready          (rdy),
    .monitor_error          (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [15:0] a);
    return {a, ~a} ^ 32'h3C5A_96E1;
  endfunction

  // Behavioural Avalon slave: memory plus a per-transfer stall count.
  logic [31:0] slave_mem [0:65535];
  bit          slave_wr  [0:65535];
  int          stall_n = 0;
  int          stall_seen = 0;

  assign avm.avm_waitrequest = (stall_seen < stall_n);
  assign avm.avm_readdata = !avm.avm_read ? 32'h0 :
                            slave_wr[avm.avm_address] ? slave_mem[avm.avm_address] :
                            init_val(avm.avm_address);

  always @(posedge clk) begin
    if (!(avm.avm_read || avm.avm_write)) stall_seen <= 0;
    else if (avm.avm_waitrequest) stall_seen <= stall_seen + 1;
    if (avm.avm_write && !avm.avm_waitrequest) begin
      slave_mem[avm.avm_address] <= avm.avm_writedata;
      slave_wr[avm.avm_address]  <= 1'b1;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:65535];
  bit          ref_wr  [0:65535];
  logic [15:0] m_addr = '0;
  logic [31:0] m_mon = '0;
  bit          m_err = 1'b0;
  op_t         op_q[$];
  res_t        res_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks bus transfers and each result presented by a rising monitor_ready.
  initial begin
    bit   prev = 1'b1;
    int   req_cnt = 0;
    op_t  op;
    res_t r;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
        req_cnt = 0;
        continue;
      end
      if (avm.avm_read || avm.avm_write) begin
        req_cnt++;
        if (!avm.avm_waitrequest) begin
          if (op_q.size() == 0) begin
            check("unexpected bus op", {avm.avm_write, avm.avm_read}, 0);
          end else begin
            op = op_q.pop_front();
            check("op kind", {avm.avm_write, avm.avm_read}, op.is_wr ? 2'b10 : 2'b01);
            check("op addr", avm.avm_address, op.addr);
            if (op.is_wr) check("op wdata", avm.avm_writedata, op.data);
          end
        end
      end
      if (rdy && !prev) begin
        if (res_q.size() == 0) begin
          check("unexpected result", 1, 0);
        end else begin
          r = res_q.pop_front();
          check("MonDReg", mon, r.mon);
          check("monitor_error", err, r.err);
          check("address after", avm.avm_address, r.addr);
          check("request cycles", req_cnt, r.reqcyc);
        end
        req_cnt = 0;
      end
      prev = rdy;
    end
  end

  function automatic logic [37:0] rnd_jdo();
    return 38'({$urandom(), $urandom()});
  endfunction

  function automatic logic [37:0] mk_a(input logic [15:0] a, input bit rd);
    logic [37:0] j;
    j = rnd_jdo();
    j[17:2] = a;
    j[35] = rd;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = rnd_jdo();
    j[34:3] = d;
    return j;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!rdy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("ready within bound", rdy, 1);
  endtask

  // Called at a negedge; applies the model, issues the strobe(s), waits for completion.
  task automatic cmd(input logic [37:0] j, input bit a, input bit n, input bit b,
                     input int stall, input bit ovr);
    int          kind;
    int          reqcyc;
    int          k;
    int          cnt;
    op_t         op;
    res_t        r;
    logic [31:0] jw;
    jw = j[34:3];
    cnt = int'(a) + int'(n) + int'(b);
    kind = 0;
    reqcyc = 0;
    if (a) begin
      m_addr = j[17:2];
      if (j[35]) kind = 1;
    end else if (n) begin
      kind = 1;
    end else if (b) begin
      kind = 2;
    end
    if (kind != 0) m_err = 1'b0;
    if (cnt > 1) m_err = 1'b1;
    if (kind != 0) begin
      if (stall < TO) begin
        op.is_wr = (kind == 2);
        op.addr  = m_addr;
        op.data  = jw;
        op_q.push_back(op);
        if (kind == 1) begin
          m_mon = ref_wr[m_addr] ? ref_mem[m_addr] : init_val(m_addr);
        end else begin
          ref_mem[m_addr] = jw;
          ref_wr[m_addr]  = 1'b1;
        end
        m_addr = m_addr + 16'd1;
        reqcyc = stall + 1;
      end else begin
        m_err = 1'b1;
        reqcyc = TO;
      end
      if (ovr) m_err = 1'b1;
      r.mon = m_mon;
      r.err = m_err;
      r.addr = m_addr;
      r.reqcyc = reqcyc;
      res_q.push_back(r);
    end
    stall_n = stall;
    jdo = j;
    sa = a;
    sn = n;
    sb = b;
    @(negedge clk);
    sa = 1'b0;
    sn = 1'b0;
    sb = 1'b0;
    if (kind == 0) begin
      check("load address", avm.avm_address, m_addr);
      check("load error", err, m_err);
      check("load ready", rdy, 1);
      return;
    end
    if (ovr) begin
      k = $urandom_range(0, reqcyc - 1);
      repeat (k) @(negedge clk);
      jdo = rnd_jdo();
      {sa, sn, sb} = 3'($urandom_range(1, 7));
      @(negedge clk);
      sa = 1'b0;
      sn = 1'b0;
      sb = 1'b0;
    end
    wait_ready();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sel, stall;
    logic [37:0] j;
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i] = '0;
      ref_wr[i]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset avm_read", avm.avm_read, 0);
    check("reset avm_write", avm.avm_write, 0);
    check("reset avm_address", avm.avm_address, 0);
    check("reset avm_writedata", avm.avm_writedata, 0);
    check("reset MonDReg", mon, 0);
    check("reset monitor_ready", rdy, 1);
    check("reset monitor_error", err, 0);

    // Load + read of a known value.
    cmd(mk_a(16'h0010, 1'b0), 1, 0, 0, 0, 0);
    cmd(mk_b(32'hCAFE_F00D), 0, 0, 1, 0, 0);
    cmd(mk_a(16'h0010, 1'b1), 1, 0, 0, 0, 0);
    // Burst write across the wrap, then read one back.
    cmd(mk_a(16'hFFFE, 1'b0), 1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) cmd(mk_b(32'(i)), 0, 0, 1, 0, 0);
    cmd(mk_a(16'hFFFF, 1'b1), 1, 0, 0, 0, 0);
    // Stall, timeout, recovery.
    cmd(rnd_jdo(), 0, 1, 0, 5, 0);
    cmd(rnd_jdo(), 0, 1, 0, 20, 0);
    cmd(rnd_jdo(), 0, 1, 0, 0, 0);
    cmd(rnd_jdo(), 0, 1, 0, 7, 0);
    // Overrun during a stalled read, then simultaneous strobes in idle.
    cmd(rnd_jdo(), 0, 1, 0, 4, 1);
    cmd(mk_a(16'h1234, 1'b1), 1, 0, 1, 0, 0);
    cmd(rnd_jdo(), 0, 1, 1, 2, 0);

    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      j = rnd_jdo();
      if ($urandom_range(0, 1) == 1) j[17:2] = 16'hFFF0 + 16'($urandom_range(0, 15));
      stall = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 12) : $urandom_range(0, 3);
      case (sel)
        0, 1:    cmd(j, 1, 0, 0, stall, $urandom_range(0, 5) == 0);
        2, 3:    cmd(j, 0, 1, 0, stall, $urandom_range(0, 5) == 0);
        4, 5, 6: cmd(j, 0, 0, 1, stall, $urandom_range(0, 5) == 0);
        7:       cmd(j, 1, 0, 1, stall, 0);
        8:       cmd(j, 0, 1, 1, stall, 0);
        default: cmd(j, 1, 1, 1, stall, 0);
      endcase
    end

    // Reset while a write is stalled.
    stall_n = 30;
    jdo = mk_b(32'h1357_9BDF);
    sb = 1'b1;
    @(negedge clk);
    sb = 1'b0;
    repeat (3) @(negedge clk);
    check("write stalled before reset", avm.avm_write, 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset mid-write avm_write", avm.avm_write, 0);
    check("reset mid-write ready", rdy, 1);
    check("reset mid-write MonDReg", mon, 0);
    check("reset mid-write address", avm.avm_address, 0);
    check("reset mid-write error", err, 0);
    reset = 1'b0;
    m_addr = '0;
    m_mon = '0;
    m_err = 1'b0;
    @(negedge clk);
    cmd(rnd_jdo(), 0, 1, 0, 1, 0);

    check("op queue drained", op_q.size(), 0);
    check("result queue drained", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/niosii_jtag_debug_mem_access.md
Name: niosii_jtag_debug_mem_access

Overview:
System-clock debug memory access engine directly downstream of the JTAG debug module sysclk stage. Consumes jdo plus the ocimem take_action/take_no_action strobes, runs single-word reads and writes on an Avalon-MM master port, and returns MonDReg, monitor_ready and monitor_error to the JTAG tck stage for capture. Supports address auto-increment for burst dumps/loads and a waitrequest timeout.

Parameters:
AW, 16, word-address width of avm_address.
TIMEOUT_CYCLES, 255, consecutive waitrequest-high cycles before abort; 0 disables timeout.

Ports:
clk  in  1  system clock, same clock as the sysclk stage.
reset  in  1  synchronous, active-high reset.
jdo  in  38  JTAG data from sysclk stage, valid on strobe cycles.
take_action_ocimem_a  in  1  one-cycle strobe: load address, optionally read.
take_no_action_ocimem_a  in  1  one-cycle strobe: read at current address.
take_action_ocimem_b  in  1  one-cycle strobe: write jdo data at current address.
avm_address  out  AW  word address.
avm_read  out  1  read request.
avm_write  out  1  write request.
avm_writedata  out  32  write data.
avm_readdata  in  32  read data, valid when avm_read=1 and avm_waitrequest=0.
avm_waitrequest  in  1  slave stall.
MonDReg  out  32  last read data.
monitor_ready  out  1  1 = idle, result available.
monitor_error  out  1  sticky error (timeout or overrun).

Behaviour:
- Reset: state IDLE; avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, MonDReg=0, monitor_ready=1, monitor_error=0, timeout count=0. Reset mid-transfer aborts; request drops at that edge, no address increment.
- jdo fields: jdo[35] = read-after-load flag; address = jdo[AW+1:2]; write data = jdo[34:3]; jdo[37:36] ignored.
- IDLE, take_action_ocimem_a: avm_address <= jdo address. If jdo[35]=1, go RD; else stay IDLE. monitor_ready stays 1 on a load without read.
- IDLE, take_no_action_ocimem_a: go RD at current address.
- IDLE, take_action_ocimem_b: avm_writedata <= jdo[34:3]; go WR.
- Any accepted read or write (strobe cycle N): monitor_error <= 0, monitor_ready <= 0, request asserted from cycle N+1.
- Simultaneous strobes in IDLE: priority is ocimem_a, then no_action_ocimem_a, then ocimem_b. Losers are dropped and monitor_error <= 1 in the same edge, after the clear.
- RD: avm_read=1 until a cycle with avm_waitrequest=0. At that edge: MonDReg <= avm_readdata; avm_read <= 0; monitor_ready <= 1; avm_address <= avm_address+1 (wraps 2^AW-1 -> 0); go IDLE.
- WR: avm_write=1 until a cycle with avm_waitrequest=0. At that edge: avm_write <= 0; monitor_ready <= 1; address increments and wraps; go IDLE. MonDReg is unchanged.
- Minimum round trip: strobe N, request N+1, with waitrequest=0 at N+1 ready=1 at N+2.
- Timeout (TIMEOUT_CYCLES>0): counter increments each RD/WR cycle with waitrequest=1 and clears on entering RD/WR. When count = TIMEOUT_CYCLES-1 with waitrequest still 1: request drops, monitor_error <= 1, monitor_ready <= 1, MonDReg and address unchanged, go IDLE. Completion takes precedence over timeout in the same cycle.
- Strobe while in RD/WR (overrun): command ignored, monitor_error <= 1, transfer continues unaffected.
- monitor_error is cleared only by reset or an accepted read/write command.

Decomposition:
- Package niosii_jtag_dbg_pkg: state enum {IDLE, RD, WR}; JDO_RD_FLAG=35, JDO_ADDR_LSB=2, JDO_WDATA_LSB=3, JDO_WDATA_W=32; reset constants.
- One sub-module: niosii_jtag_dbg_timeout. Parameterised saturating counter with clear/enable inputs and an expire output. The FSM, address register and data registers stay in the top module.

Test Plan:
- Load+read: ocimem_a with jdo addr=0x0010, jdo[35]=1, slave readdata=0xCAFEF00D, waitrequest=0 -> avm_read high 1 cycle at addr 0x0010; MonDReg=0xCAFEF00D and monitor_ready=1 two cycles after strobe; avm_address=0x0011.
- Burst write: load addr 0xFFFE without read, then three ocimem_b with data 1,2,3 -> writes at 0xFFFE, 0xFFFF, 0x0000 (wrap); final avm_address=0x0001; monitor_error=0.
- Waitrequest stall: read with waitrequest high 5 cycles -> avm_read held 6 cycles, address stable; MonDReg updates on the first low cycle; no error.
- Timeout: TIMEOUT_CYCLES=8, waitrequest stuck high -> avm_read drops after 8 request cycles; monitor_error=1, monitor_ready=1, address unchanged. Next accepted read clears error.
- Overrun and priority: ocimem_b strobe during a stalled read -> error=1, read completes normally, no write issued. Simultaneous ocimem_a (read) and ocimem_b in IDLE -> only the read is issued, error=1.
- Reset mid-write: assert reset while avm_write=1 and stalled -> next edge avm_write=0, monitor_ready=1, MonDReg=0, avm_address=0.
